// File: rtl/timing_mem_loader_if.sv
// Stream bus carrying 17-bit line-data words from the host DMA path into the timing memory loader.
// Latency: none. This is a pure signal bundle.
// Backpressure: the source holds s_data/s_valid. A word is consumed on a clock edge where s_valid and s_ready are both high.
interface timing_mem_loader_if;
    logic [16:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/timing_mem_loader.sv
// Writes one full line set ((P+1)*(M+1) stream words) into the timing memories per update_mem request, then pulses mem_updated.
// Latency: request edge -> ready 1 cycle; handshake -> write port 1 cycle; last write -> mem_updated 1 cycle.
// Backpressure: s_ready is high only while loading. Optional stall abort is enabled by TIMING_LOADER_TIMEOUT_EN.
module timing_mem_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic [16:0]               s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic                      update_mem_i,
    input  logic [9:0]                points_per_line_i,
    input  logic [2:0]                mem_count_i,
    output logic [10:0]               waddr_o,
    output logic [16:0]               wdata_o,
    output logic                      we_o,
    output logic [2:0]                memory_selector_o,
    output logic                      mem_updated_o,
    output logic                      busy_o,
    output logic                      underrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2
`ifdef TIMING_LOADER_TIMEOUT_EN
        , ST_ABORT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        hist_q, hist_d;
    logic        pend_q, pend_d;
    logic [9:0]  p_q, p_d;
    logic [2:0]  m_q, m_d;
    logic [10:0] addr_q, addr_d;
    logic [2:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [10:0] waddr_q, waddr_d;
    logic [16:0] wdata_q, wdata_d;
    logic [2:0]  msel_q, msel_d;
    logic        done_q, done_d;
    logic        req, hs, last;

`ifdef TIMING_LOADER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] idle_q, idle_d;
    logic        underrun_q, underrun_d;
`endif

    assign req  = update_mem_i & ~hist_q;
    assign hs   = s_valid_i & (state_q == ST_LOAD);
    assign last = (addr_q == {1'b0, p_q}) && (sel_q == m_q);

    // Next-state, counter and write-port computation
    always_comb begin
        state_d = state_q;
        hist_d  = update_mem_i;
        pend_d  = pend_q;
        p_d     = p_q;
        m_d     = m_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        msel_d  = msel_q;
        done_d  = 1'b0;
`ifdef TIMING_LOADER_TIMEOUT_EN
        idle_d     = idle_q;
        underrun_d = underrun_q;
`endif
        // A request arriving while busy (including the DONE cycle) is queued once
        if (req && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    state_d = ST_LOAD;
                    pend_d  = 1'b0;
                    p_d     = points_per_line_i;
                    m_d     = mem_count_i;
                    addr_d  = 11'd0;
                    sel_d   = 3'd0;
`ifdef TIMING_LOADER_TIMEOUT_EN
                    idle_d     = 16'd0;
                    underrun_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data_i;
                    msel_d  = sel_q;
                    if (addr_q < {1'b0, p_q}) begin
                        addr_d = addr_q + 11'd1;
                    end else begin
                        addr_d = 11'd0;
                        sel_d  = sel_q + 3'd1;
                    end
                    if (last) begin
                        state_d = ST_DONE;
                    end
`ifdef TIMING_LOADER_TIMEOUT_EN
                    idle_d = 16'd0;
                end else if (idle_q == TIMEOUT_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    idle_d = idle_q + 16'd1;
`endif
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef TIMING_LOADER_TIMEOUT_EN
            ST_ABORT: begin
                underrun_d = 1'b1;
                pend_d     = 1'b0;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers: FSM state, request edge history, pending request
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
            hist_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pend_q  <= pend_d;
        end
    end

    // Datapath registers: latched geometry, counters, registered write port
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            p_q     <= '0;
            m_q     <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            msel_q  <= '0;
            done_q  <= 1'b0;
`ifdef TIMING_LOADER_TIMEOUT_EN
            idle_q     <= '0;
            underrun_q <= 1'b0;
`endif
        end else begin
            p_q     <= p_d;
            m_q     <= m_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            msel_q  <= msel_d;
            done_q  <= done_d;
`ifdef TIMING_LOADER_TIMEOUT_EN
            idle_q     <= idle_d;
            underrun_q <= underrun_d;
`endif
        end
    end

    assign s_ready_o         = (state_q == ST_LOAD);
    assign busy_o            = (state_q != ST_IDLE);
    assign we_o              = we_q;
    assign waddr_o           = waddr_q;
    assign wdata_o           = wdata_q;
    assign memory_selector_o = msel_q;
    assign mem_updated_o     = done_q;
`ifdef TIMING_LOADER_TIMEOUT_EN
    assign underrun_o        = underrun_q;
`else
    assign underrun_o        = 1'b0;
`endif

endmodule

// File: tb/tb_timing_mem_loader.sv
// Bench for timing_mem_loader: randomized and directed loads, checked against a line-set reference model.
// Latency: the model predicts every output one cycle ahead from the inputs sampled at each clock edge.
// Backpressure: the stream source only advances its data when s_ready was high at the sampling edge.
module tb_timing_mem_loader;
    localparam int MI = 0, ML = 1, MD = 2, MA = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        upd;
    logic [9:0]  ppl;
    logic [2:0]  mc;
    logic [10:0] waddr;
    logic [16:0] wdata;
    logic        we, mupd, busy, under;
    logic [2:0]  msel;

    timing_mem_loader_if sif ();

    timing_mem_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .nrst_i(nrst),
        .s_data_i(sif.s_data), .s_valid_i(sif.s_valid), .s_ready_o(sif.s_ready),
        .update_mem_i(upd),
        .points_per_line_i(ppl), .mem_count_i(mc), .waddr_o(waddr), .wdata_o(wdata),
        .we_o(we), .memory_selector_o(msel), .mem_updated_o(mupd), .busy_o(busy),
        .underrun_o(under)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [30:0] obs_q[$];

    // Reference model: one load = (P+1)*(M+1) words, word i lands at sel i/(P+1), addr i%(P+1)
    int          m_mode = MI;
    bit          m_pend = 0, m_hist = 0, m_req;
    int          m_p, m_m, m_idx, m_total, m_idle;
    bit          e_ready = 0, e_we = 0, e_done = 0, e_busy = 0, e_under = 0;
    logic [10:0] e_addr = '0;
    logic [16:0] e_data = '0;
    logic [2:0]  e_sel = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge nrst);
        if (nrst !== 1'b1) begin
            m_mode = MI; m_pend = 0; m_hist = 0; m_idle = 0;
            e_ready = 0; e_we = 0; e_done = 0; e_busy = 0; e_under = 0;
            e_addr = '0; e_data = '0; e_sel = '0;
        end else begin
            m_req = upd && !m_hist;
            m_hist = upd;
            e_we = 0;
            e_done = 0;
            case (m_mode)
                MI: if (m_req || m_pend) begin
                        m_mode = ML; m_pend = 0; m_idx = 0; m_idle = 0; e_under = 0;
                        m_p = int'(ppl); m_m = int'(mc);
                        m_total = (m_p + 1) * (m_m + 1);
                    end
                ML: begin
                        if (m_req) m_pend = 1;
                        if (sif.s_valid) begin
                            e_we = 1;
                            e_addr = 11'(m_idx % (m_p + 1));
                            e_sel = 3'(m_idx / (m_p + 1));
                            e_data = sif.s_data;
                            m_idx++;
                            m_idle = 0;
                            if (m_idx == m_total) m_mode = MD;
                        end
`ifdef TIMING_LOADER_TIMEOUT_EN
                        else begin
                            m_idle++;
                            if (m_idle == TO) m_mode = MA;
                        end
`endif
                    end
                MD: begin
                        if (m_req) m_pend = 1;
                        e_done = 1;
                        m_mode = MI;
                    end
                default: begin
                        e_under = 1;
                        m_pend = 0;
                        m_mode = MI;
                    end
            endcase
            e_ready = (m_mode == ML);
            e_busy = (m_mode != MI);
        end
    end

    // Compare every cycle against the model
    initial forever begin
        @(negedge clk);
        if (nrst === 1'b1) begin
            check("ctl{rdy,we,upd,busy,urun}", 64'({sif.s_ready, we, mupd, busy, under}),
                  64'({e_ready, e_we, e_done, e_busy, e_under}));
            check("wport{sel,addr,data}", 64'({msel, waddr, wdata}), 64'({e_sel, e_addr, e_data}));
            if (we === 1'b1) obs_q.push_back({msel, waddr, wdata});
            if (mupd === 1'b1) done_cnt++;
        end
    end

    task automatic request();
        upd = 1'b1;
        @(posedge clk); #1;
        upd = 1'b0;
    endtask

    // pat: 0 valid held, 1 valid toggling 1/0, 2 random valid
    task automatic send(input int n, input int pat, input logic [16:0] base);
        int sent = 0;
        int cyc = 0;
        bit v, acc;
        while (sent < n && cyc < n * 4 + 64) begin
            case (pat)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            sif.s_valid = v;
            sif.s_data = base + 17'(sent);
            @(negedge clk);
            acc = v && (sif.s_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        sif.s_valid = 1'b0;
        check("send_words_accepted", 64'(sent), 64'(n));
    endtask

    task automatic wait_idle();
        int c = 0;
        while (!(m_mode == MI && !m_pend && busy === 1'b0) && c < 20000) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (2) begin @(posedge clk); #1; end
        if (c >= 20000) check("wait_idle_budget", 64'(c), 64'(0));
    endtask

    initial begin
        int b, d, np, nm;
        logic [30:0] w;
        logic [13:0] t2_exp [6];
        t2_exp = '{{3'd0, 11'd0}, {3'd0, 11'd1}, {3'd1, 11'd0}, {3'd1, 11'd1}, {3'd2, 11'd0}, {3'd2, 11'd1}};
        nrst = 1'b0; upd = 1'b0; ppl = '0; mc = '0; sif.s_valid = 1'b0; sif.s_data = '0;
        #1;
        check("rst_ready", 64'(sif.s_ready), 64'(0));
        check("rst_we", 64'(we), 64'(0));
        check("rst_mem_updated", 64'(mupd), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_underrun", 64'(under), 64'(0));
        check("rst_wport", 64'({msel, waddr, wdata}), 64'(0));
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;

        // P=3, M=0, four words back to back
        ppl = 10'd3; mc = 3'd0; b = obs_q.size(); d = done_cnt;
        request(); send(4, 0, 17'h00010); wait_idle();
        check("t1_nwrites", 64'(obs_q.size() - b), 64'(4));
        check("t1_first", 64'(obs_q[b]), 64'({3'd0, 11'd0, 17'h00010}));
        check("t1_last", 64'(obs_q[b + 3]), 64'({3'd0, 11'd3, 17'h00013}));
        check("t1_done", 64'(done_cnt - d), 64'(1));

        // P=1, M=2, toggling valid
        ppl = 10'd1; mc = 3'd2; b = obs_q.size(); d = done_cnt;
        request(); send(6, 1, 17'h00100); wait_idle();
        for (int i = 0; i < 6; i++) begin
            w = obs_q[b + i];
            check("t2_order", 64'(w[30:17]), 64'(t2_exp[i]));
        end
        check("t2_done", 64'(done_cnt - d), 64'(1));

        // Two extra requests during a load: one queued, one dropped
        ppl = 10'd2; mc = 3'd1; b = obs_q.size(); d = done_cnt;
        request();
        fork
            send(12, 1, 17'h00200);
            begin
                repeat (2) begin @(posedge clk); #1; end
                request();
                @(posedge clk); #1;
                request();
            end
        join
        wait_idle();
        check("t3_done", 64'(done_cnt - d), 64'(2));
        check("t3_nwrites", 64'(obs_q.size() - b), 64'(12));

        // P changed mid-load has no effect until the next request
        ppl = 10'd3; mc = 3'd0; b = obs_q.size();
        request();
        fork
            send(4, 0, 17'h00300);
            begin @(posedge clk); #1; ppl = 10'd7; end
        join
        wait_idle();
        check("t4_nwrites_a", 64'(obs_q.size() - b), 64'(4));
        b = obs_q.size();
        request(); send(8, 2, 17'h00400); wait_idle();
        check("t4_nwrites_b", 64'(obs_q.size() - b), 64'(8));
        w = obs_q[b + 7];
        check("t4_last_addr", 64'(w[27:17]), 64'(7));

        // Smallest line set: one word
        ppl = 10'd0; mc = 3'd0; b = obs_q.size(); d = done_cnt;
        request(); send(1, 0, 17'h1ABCD); wait_idle();
        check("t5_single", 64'(obs_q[b]), 64'({3'd0, 11'd0, 17'h1ABCD}));
        check("t5_done", 64'(done_cnt - d), 64'(1));

        // Random geometries and valid patterns
        d = done_cnt;
        for (int k = 0; k < 6; k++) begin
            np = $urandom_range(0, 9); nm = $urandom_range(0, 3);
            ppl = 10'(np); mc = 3'(nm);
            request(); send((np + 1) * (nm + 1), 2, 17'($urandom)); wait_idle();
        end
        check("rand_done", 64'(done_cnt - d), 64'(6));

        // Largest line set: 1024 x 8 words
        ppl = 10'd1023; mc = 3'd7; b = obs_q.size();
        request(); send(8192, 0, 17'h0); wait_idle();
        check("big_nwrites", 64'(obs_q.size() - b), 64'(8192));
        check("big_last", 64'(obs_q[b + 8191]), 64'({3'd7, 11'd1023, 17'h01FFF}));

        // Asynchronous reset after 2 of 4 words
        ppl = 10'd3; mc = 3'd0;
        request(); send(2, 0, 17'h00500);
        #1 nrst = 1'b0;
        #1;
        check("arst_we", 64'(we), 64'(0));
        check("arst_wport", 64'({msel, waddr, wdata}), 64'(0));
        check("arst_ctl", 64'({sif.s_ready, mupd, busy, under}), 64'(0));
        d = done_cnt;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
        check("arst_no_done", 64'(done_cnt - d), 64'(0));
        b = obs_q.size();
        request(); send(4, 0, 17'h00600); wait_idle();
        check("arst_restart", 64'(obs_q[b]), 64'({3'd0, 11'd0, 17'h00600}));
        check("arst_done", 64'(done_cnt - d), 64'(1));

`ifdef TIMING_LOADER_TIMEOUT_EN
        // Stall after one word until the idle limit aborts the load
        ppl = 10'd3; mc = 3'd0; d = done_cnt;
        request(); send(1, 0, 17'h00700);
        repeat (20) begin @(posedge clk); #1; end
        check("to_underrun", 64'(under), 64'(1));
        check("to_idle", 64'(busy), 64'(0));
        check("to_no_done", 64'(done_cnt - d), 64'(0));
        request(); send(4, 0, 17'h00710); wait_idle();
        check("to_underrun_clr", 64'(under), 64'(0));
        check("to_done", 64'(done_cnt - d), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
